// File: rtl/seq_det_param_pkg.sv
// seq_det_param_pkg: FSM state encoding and active-length mask helper for the sequence detector
package seq_det_param_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, ARMED = 2'd2, MATCH = 2'd3} state_e;
  localparam int MASK_MAX = 64;
  function automatic logic [MASK_MAX-1:0] len_mask(input int unsigned len);
    return (len >= MASK_MAX) ? '1 : (MASK_MAX'(1) << len) - 1'b1;
  endfunction
endpackage

// File: rtl/seq_det_param_if.sv
// seq_det_param_if: serial stream, config load and detection status bundle
interface seq_det_param_if #(
  parameter int SEQ_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
);
  logic             in;
  logic             in_valid;
  logic             load;
  logic [SEQ_W-1:0] pattern_in;
  logic [SEQ_W-1:0] mask_in;
  logic [LEN_W-1:0] len_in;
  logic             ovl_in;
  logic             det;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic             cfg_err;
  modport master (
    output in, in_valid, load, pattern_in, mask_in, len_in, ovl_in,
    input  det, match_cnt, cnt_sat, cfg_err
  );
  modport slave (
    input  in, in_valid, load, pattern_in, mask_in, len_in, ovl_in,
    output det, match_cnt, cnt_sat, cfg_err
  );
endinterface

// File: rtl/seq_hist_shift.sv
// seq_hist_shift: serial history shift register with a fill counter saturating at SEQ_W
module seq_hist_shift #(
  parameter int SEQ_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             in,
  output logic [SEQ_W-1:0] hist,
  output logic [LEN_W-1:0] fill
);
  logic [SEQ_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  always_comb begin
    hist_d = clr ? '0 : shift ? {hist_q[SEQ_W-2:0], in} : hist_q;
    fill_d = clr ? '0 : (shift && fill_q != LEN_W'(SEQ_W)) ? fill_q + 1'b1 : fill_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
  assign hist = hist_q;
  assign fill = fill_q;
endmodule

// File: rtl/seq_det_param.sv
// seq_det_param: runtime-programmable Moore serial sequence detector with saturating match counter
module seq_det_param
  import seq_det_param_pkg::*;
#(
  parameter int               SEQ_W    = 8,
  parameter int               LEN_W    = 4,
  parameter int               CNT_W    = 8,
  parameter logic [SEQ_W-1:0] DEF_PAT  = 8'b0000_1010,
  parameter logic [LEN_W-1:0] DEF_LEN  = 4,
  parameter logic [SEQ_W-1:0] DEF_MASK = '1,
  parameter logic             DEF_OVL  = 1'b1
) (
  input logic            clk,
  input logic            rst,
  seq_det_param_if.slave bus
);
  logic [SEQ_W-1:0] pat_q, pat_d, mask_q, mask_d, hist, lenmask;
  logic [LEN_W-1:0] len_q, len_d, fill, nxt_fill;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovl_q, ovl_d, det_q, det_d, sat_q, sat_d, err_q, err_d;
  logic             legal_in, accept, hit, clr;
  logic [SEQ_W:0]   win;
  state_e           st_q, st_d;
  seq_hist_shift #(.SEQ_W(SEQ_W), .LEN_W(LEN_W)) u_hist (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .shift (accept),
    .in    (bus.in),
    .hist  (hist),
    .fill  (fill)
  );
  // win carries the post-shift history; its top bit is the bit falling off and never compared
  always_comb begin
    legal_in = bus.len_in != '0 && bus.len_in <= LEN_W'(SEQ_W);
    accept   = bus.in_valid && !bus.load && st_q != IDLE;
    win      = {hist, bus.in};
    nxt_fill = (fill == LEN_W'(SEQ_W)) ? fill : fill + 1'b1;
    lenmask  = SEQ_W'(len_mask(32'(len_q)));
    hit      = accept && nxt_fill >= len_q &&
               ((win ^ {1'b0, pat_q}) & {1'b0, mask_q & lenmask}) == '0;
    clr      = bus.load || (hit && !ovl_q);
    pat_d    = pat_q;
    mask_d   = mask_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    det_d    = 1'b0;
    if (bus.load) begin
      pat_d  = bus.pattern_in;
      mask_d = bus.mask_in;
      len_d  = bus.len_in;
      ovl_d  = bus.ovl_in;
      err_d  = !legal_in;
      cnt_d  = '0;
      st_d   = legal_in ? FILL : IDLE;
    end else if (hit) begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
      det_d = 1'b1;
      st_d  = MATCH;
    end else if (accept) begin
      st_d = nxt_fill >= len_q ? ARMED : FILL;
    end else if (st_q == MATCH) begin
      st_d = ovl_q ? ARMED : FILL;
    end
    sat_d = &cnt_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= DEF_PAT;
      mask_q <= DEF_MASK;
      len_q  <= DEF_LEN;
      ovl_q  <= DEF_OVL;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      det_q  <= 1'b0;
      st_q   <= FILL;
    end else begin
      pat_q  <= pat_d;
      mask_q <= mask_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      det_q  <= det_d;
      st_q   <= st_d;
    end
  end
  assign bus.det       = det_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = sat_q;
  assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: directed and random stimulus checked against a bit-queue reference model
module tb_seq_det_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  seq_det_param_if #(.SEQ_W(8), .LEN_W(4), .CNT_W(8)) bus ();
  seq_det_param_if #(.SEQ_W(8), .LEN_W(4), .CNT_W(2)) bus2 ();
  seq_det_param #(.CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  seq_det_param #(.CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] cfg_pat = 8'h0A;
  logic [7:0] cfg_mask = 8'hFF;
  logic [3:0] cfg_len = 4'd4;
  logic       cfg_ovl = 1'b1;
  logic [7:0] m_pat, m_mask;
  int         m_len, m_cnt;
  logic       m_ovl, m_err, m_det;
  bit         m_q[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  // m_q holds accepted bits since the last clear, newest last, at most 8 deep
  task automatic model(input logic r, input logic v, input logic b, input logic ld);
    bit ok;
    if (r) begin
      m_pat = 8'h0A; m_mask = 8'hFF; m_len = 4; m_ovl = 1'b1;
      m_err = 1'b0; m_det = 1'b0; m_cnt = 0; m_q.delete();
    end else if (ld) begin
      m_pat = cfg_pat; m_mask = cfg_mask; m_len = int'(cfg_len); m_ovl = cfg_ovl;
      m_err = (cfg_len == 4'd0 || cfg_len > 4'd8); m_det = 1'b0; m_cnt = 0; m_q.delete();
    end else if (v && !m_err) begin
      m_q.push_back(b);
      if (m_q.size() > 8) void'(m_q.pop_front());
      ok = m_q.size() >= m_len;
      for (int i = 0; i < m_len && ok; i++)
        if (m_mask[i] && m_q[m_q.size()-1-i] != m_pat[i]) ok = 0;
      m_det = ok;
      if (ok) begin
        m_cnt++;
        if (!m_ovl) m_q.delete();
      end
    end else m_det = 1'b0;
  endtask
  task automatic drive(input logic r, input logic v, input logic b, input logic ld);
    rst = r;
    bus.in = b;              bus2.in = b;
    bus.in_valid = v;        bus2.in_valid = v;
    bus.load = ld;           bus2.load = ld;
    bus.pattern_in = cfg_pat; bus2.pattern_in = cfg_pat;
    bus.mask_in = cfg_mask;  bus2.mask_in = cfg_mask;
    bus.len_in = cfg_len;    bus2.len_in = cfg_len;
    bus.ovl_in = cfg_ovl;    bus2.ovl_in = cfg_ovl;
    @(posedge clk);
    model(r, v, b, ld);
    #1;
    check("det", 32'(bus.det), 32'(m_det));
    check("match_cnt", 32'(bus.match_cnt), (m_cnt > 255) ? 255 : m_cnt);
    check("cnt_sat", 32'(bus.cnt_sat), 32'(m_cnt >= 255));
    check("cfg_err", 32'(bus.cfg_err), 32'(m_err));
    check("det_w2", 32'(bus2.det), 32'(m_det));
    check("match_cnt_w2", 32'(bus2.match_cnt), (m_cnt > 3) ? 3 : m_cnt);
    check("cnt_sat_w2", 32'(bus2.cnt_sat), 32'(m_cnt >= 3));
    check("cfg_err_w2", 32'(bus2.cfg_err), 32'(m_err));
  endtask
  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, bits[i], 1'b0);
  endtask
  task automatic load_cfg(input logic [7:0] p, input logic [7:0] m, input logic [3:0] l, input logic o);
    cfg_pat = p; cfg_mask = m; cfg_len = l; cfg_ovl = o;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    logic r, ld;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    send(32'b1010111111010, 13);
    check("t1_cnt", 32'(bus.match_cnt), 2);
    load_cfg(8'h0A, 8'hFF, 4'd4, 1'b0);
    send(32'b101010, 6);
    check("t2_novl_cnt", 32'(bus.match_cnt), 1);
    load_cfg(8'h0A, 8'hFF, 4'd4, 1'b1);
    send(32'b101010, 6);
    check("t2_ovl_cnt", 32'(bus.match_cnt), 2);
    load_cfg(8'hD3, 8'hF3, 4'd8, 1'b1);
    send(32'b11011111, 8);
    check("t3_masked_det", 32'(bus.det), 1);
    load_cfg(8'hD3, 8'hFF, 4'd8, 1'b1);
    send(32'b11011111, 8);
    check("t3_full_cnt", 32'(bus.match_cnt), 0);
    load_cfg(8'h03, 8'hFF, 4'd2, 1'b1);
    send(32'b1111111, 7);
    check("t4_cnt8", 32'(bus.match_cnt), 6);
    check("t4_cnt2", 32'(bus2.match_cnt), 3);
    check("t4_sat2", 32'(bus2.cnt_sat), 1);
    load_cfg(8'h0A, 8'hFF, 4'd0, 1'b1);
    send(32'b1010, 4);
    check("t5_err_len0", 32'(bus.cfg_err), 1);
    load_cfg(8'h0A, 8'hFF, 4'd9, 1'b1);
    send(32'b1010, 4);
    check("t5_err_len9", 32'(bus.cfg_err), 1);
    load_cfg(8'h05, 8'hFF, 4'd3, 1'b1);
    send(32'b101, 3);
    check("t5_resume_cnt", 32'(bus.match_cnt), 1);
    load_cfg(8'h0A, 8'hFF, 4'd4, 1'b1);
    send(32'b101, 3);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check("t6_load_det", 32'(bus.det), 0);
    check("t6_load_cnt", 32'(bus.match_cnt), 0);
    send(32'b10, 2);
    idle(3);
    send(32'b10, 2);
    check("t6_gap_cnt", 32'(bus.match_cnt), 1);
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 29) == 0);
      if (ld) begin
        cfg_pat = 8'($urandom);
        cfg_mask = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
        cfg_len = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
        cfg_ovl = 1'($urandom);
      end
      drive(r, 1'($urandom_range(0, 3) != 0), 1'($urandom), ld);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
